// File: rtl/bram_arb_pkg.sv
// rtl/bram_arb_pkg.sv - shared types and defaults for the BRAM read-port arbiter
package bram_arb_pkg;
  localparam int BRAM_ADDR_W = 8;
  localparam int BRAM_DATA_W = 17;
  localparam int BRAM_LEN_W  = 9;
  localparam int MAX_LEN     = 256;

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} arb_state_t;

  typedef struct packed {
    logic valid;
    logic owner;
    logic last;
  } rd_tag_t;

  function automatic logic [1:0] owner_onehot(input logic owner);
    return owner ? 2'b10 : 2'b01;
  endfunction
endpackage

// File: rtl/rd_lat_pipe.sv
// rtl/rd_lat_pipe.sv - delays read tags by the BRAM read latency
// Each stage holds the tag of one issued read; output aligns with doutb.
module rd_lat_pipe
  import bram_arb_pkg::*;
#(
  parameter int DEPTH = 1
) (
  input  logic    clk,
  input  logic    rst_n,
  input  rd_tag_t tag_in,
  output rd_tag_t tag_out
);
  rd_tag_t stage_q [DEPTH];
  rd_tag_t stage_d [DEPTH];

  always_comb begin
    stage_d[0] = tag_in;
    for (int i = 1; i < DEPTH; i++) begin
      stage_d[i] = stage_q[i-1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        stage_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        stage_q[i] <= stage_d[i];
      end
    end
  end

  assign tag_out = stage_q[DEPTH-1];
endmodule

// File: rtl/bram_read_arbiter.sv
// rtl/bram_read_arbiter.sv - round-robin burst arbiter for a shared BRAM read port
// Grants one burst at a time, issues one read per cycle and tags returning data.
module bram_read_arbiter
  import bram_arb_pkg::*;
#(
  parameter int ADDR_W = BRAM_ADDR_W,
  parameter int DATA_W = BRAM_DATA_W,
  parameter int LEN_W  = BRAM_LEN_W,
  parameter int RD_LAT = 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [1:0]             req_valid,
  output logic [1:0]             req_ready,
  input  logic [1:0][ADDR_W-1:0] req_addr,
  input  logic [1:0][LEN_W-1:0]  req_len,
  output logic                   bram_en,
  output logic [ADDR_W-1:0]      bram_addr,
  input  logic [DATA_W-1:0]      bram_dout,
  output logic [1:0]             rsp_valid,
  output logic [DATA_W-1:0]      rsp_data,
  output logic                   rsp_last,
  output logic [1:0]             done,
  output logic                   busy
);
  arb_state_t        state_q, state_d;
  logic [ADDR_W-1:0] cur_addr_q, cur_addr_d;
  logic [LEN_W-1:0]  remaining_q, remaining_d;
  logic              owner_q, owner_d;
  logic              last_grant_q, last_grant_d;
  logic              busy_q, busy_d;
  logic              zero_len_q, zero_len_d;

  logic [1:0]        grant;
  logic              sel;
  logic [LEN_W-1:0]  len_sel;
  logic [LEN_W-1:0]  len_sat;
  rd_tag_t           tag_in;
  rd_tag_t           tag_out;

  // Contention goes to whichever requester did not win last time.
  always_comb begin
    grant = 2'b00;
    case (req_valid)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = last_grant_q ? 2'b01 : 2'b10;
      default: grant = 2'b00;
    endcase
  end

  assign sel     = grant[1];
  assign len_sel = req_len[sel];
  assign len_sat = (len_sel > LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : len_sel;

  always_comb begin
    state_d      = state_q;
    cur_addr_d   = cur_addr_q;
    remaining_d  = remaining_q;
    owner_d      = owner_q;
    last_grant_d = last_grant_q;
    busy_d       = busy_q;
    zero_len_d   = zero_len_q;
    bram_en      = 1'b0;
    tag_in       = '0;
    case (state_q)
      IDLE: begin
        if (grant != 2'b00) begin
          owner_d      = sel;
          last_grant_d = sel;
          cur_addr_d   = req_addr[sel];
          remaining_d  = len_sat;
          busy_d       = 1'b1;
          zero_len_d   = (len_sel == '0);
          state_d      = (len_sel == '0) ? DRAIN : ISSUE;
        end
      end
      ISSUE: begin
        bram_en      = 1'b1;
        tag_in.valid = 1'b1;
        tag_in.owner = owner_q;
        tag_in.last  = (remaining_q == LEN_W'(1));
        cur_addr_d   = cur_addr_q + ADDR_W'(1);
        remaining_d  = remaining_q - LEN_W'(1);
        if (remaining_q == LEN_W'(1)) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (zero_len_q || (tag_out.valid && tag_out.last)) begin
          state_d    = IDLE;
          busy_d     = 1'b0;
          zero_len_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      cur_addr_q   <= '0;
      remaining_q  <= '0;
      owner_q      <= 1'b0;
      last_grant_q <= 1'b1;
      busy_q       <= 1'b0;
      zero_len_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      cur_addr_q   <= cur_addr_d;
      remaining_q  <= remaining_d;
      owner_q      <= owner_d;
      last_grant_q <= last_grant_d;
      busy_q       <= busy_d;
      zero_len_q   <= zero_len_d;
    end
  end

  rd_lat_pipe #(.DEPTH(RD_LAT)) u_pipe (
    .clk     (clk),
    .rst_n   (reset),
    .tag_in  (tag_in),
    .tag_out (tag_out)
  );

  // Ready is gated by reset so a held request cannot appear accepted during reset.
  assign req_ready = (state_q == IDLE && reset) ? grant : 2'b00;
  assign bram_addr = bram_en ? cur_addr_q : '0;
  assign rsp_valid = tag_out.valid ? owner_onehot(tag_out.owner) : 2'b00;
  assign rsp_data  = tag_out.valid ? bram_dout : '0;
  assign rsp_last  = tag_out.valid & tag_out.last;
  assign done      = (rsp_valid & {2{tag_out.last}})
                   | ((state_q == DRAIN && zero_len_q) ? owner_onehot(owner_q) : 2'b00);
  assign busy      = busy_q;
endmodule

// File: tb/tb_bram_read_arbiter.sv
// tb/tb_bram_read_arbiter.sv - scoreboard bench for bram_read_arbiter at RD_LAT 1 and 2
module tb_bram_read_arbiter;
  localparam int AW = 8;
  localparam int DW = 17;
  localparam int LW = 9;

  typedef struct {
    longint cyc;
    longint val;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input int lat, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s (RD_LAT=%0d): got 0x%0h required 0x%0h", name, lat, act, exp);
    end
  endtask

  for (genvar g = 0; g < 2; g++) begin : lane
    localparam int LAT = g + 1;

    logic                rst_n;
    logic [1:0]          req_valid, req_ready;
    logic [1:0][AW-1:0]  req_addr;
    logic [1:0][LW-1:0]  req_len;
    logic                bram_en;
    logic [AW-1:0]       bram_addr;
    logic [DW-1:0]       bram_dout;
    logic [1:0]          rsp_valid;
    logic [DW-1:0]       rsp_data;
    logic                rsp_last;
    logic [1:0]          done;
    logic                busy;
    logic [DW-1:0]       mem_d1 = '0;
    logic [DW-1:0]       mem_d2 = '0;
    longint              cyc = 0;
    logic                fin_l = 1'b0;
    int                  last_grant;
    exp_t                addr_q[$];
    exp_t                rsp_q[$];
    exp_t                done_q[$];

    bram_read_arbiter #(.ADDR_W(AW), .DATA_W(DW), .LEN_W(LW), .RD_LAT(LAT)) dut (
      .clk(clk), .reset(rst_n),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_addr(req_addr), .req_len(req_len),
      .bram_en(bram_en), .bram_addr(bram_addr), .bram_dout(bram_dout),
      .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_last(rsp_last),
      .done(done), .busy(busy)
    );

    // BRAM preloaded with word[a] = a
    always @(posedge clk) begin
      cyc <= cyc + 1;
      if (bram_en) mem_d1 <= DW'(bram_addr);
      mem_d2 <= mem_d1;
    end
    assign bram_dout = (LAT == 1) ? mem_d1 : mem_d2;

    always @(negedge clk) begin
      exp_t e;
      if (rst_n) begin
        if (busy) check("ready_while_busy", LAT, req_ready, 0);
        if (bram_en) begin
          check("bram_en_expected", LAT, addr_q.size() > 0, 1);
          if (addr_q.size() > 0) begin
            e = addr_q.pop_front();
            check("bram_addr", LAT, bram_addr, e.val);
            check("bram_addr_cycle", LAT, cyc, e.cyc);
          end
        end
        if (rsp_valid != 2'b00) begin
          check("rsp_expected", LAT, rsp_q.size() > 0, 1);
          if (rsp_q.size() > 0) begin
            e = rsp_q.pop_front();
            check("rsp_owner_last_data", LAT, {rsp_valid, rsp_last, rsp_data}, e.val);
            check("rsp_cycle", LAT, cyc, e.cyc);
          end
        end else begin
          check("rsp_idle_zero", LAT, {rsp_last, rsp_data}, 0);
        end
        if (done != 2'b00) begin
          check("done_expected", LAT, done_q.size() > 0, 1);
          if (done_q.size() > 0) begin
            e = done_q.pop_front();
            check("done_value", LAT, done, e.val);
            check("done_cycle", LAT, cyc, e.cyc);
          end
        end
      end
    end

    task automatic push_burst(input int who, input int a, input int n_req, input longint t,
                              output longint end_cyc);
      int   n;
      exp_t e;
      n = (n_req > 256) ? 256 : n_req;
      for (int k = 0; k < n; k++) begin
        e.cyc = t + 1 + k;
        e.val = (a + k) % 256;
        addr_q.push_back(e);
        e.cyc = t + 1 + LAT + k;
        e.val = ((who ? 2 : 1) << 18) | ((k == n - 1 ? 1 : 0) << 17) | ((a + k) % 256);
        rsp_q.push_back(e);
      end
      e.cyc = (n == 0) ? t + 1 : t + n + LAT;
      e.val = who ? 2 : 1;
      done_q.push_back(e);
      end_cyc = e.cyc + 1;
    endtask

    task automatic run(input logic [1:0] v, input int a0, input int n0, input int a1, input int n1);
      int     pend;
      int     bound;
      int     w;
      longint end_cyc;
      pend  = v;
      bound = 0;
      @(negedge clk);
      req_addr[0] = AW'(a0);
      req_len[0]  = LW'(n0);
      req_addr[1] = AW'(a1);
      req_len[1]  = LW'(n1);
      req_valid   = v;
      while (pend != 0) begin
        #2;
        if (req_ready != 2'b00) begin
          w = (pend == 3) ? (last_grant ? 0 : 1) : ((pend == 2) ? 1 : 0);
          check("grant", LAT, req_ready, w ? 2 : 1);
          push_burst(w, w ? a1 : a0, w ? n1 : n0, cyc, end_cyc);
          last_grant = w;
          pend = pend & ~(1 << w);
          @(negedge clk);
          req_valid[w] = 1'b0;
          while (cyc < end_cyc - 1) @(negedge clk);
          #2;
          check("busy_at_done", LAT, busy, 1);
          @(negedge clk);
          #2;
          check("busy_after_done", LAT, busy, 0);
          check("queues_drained", LAT, addr_q.size() + rsp_q.size() + done_q.size(), 0);
        end else begin
          bound++;
          if (bound > 300) begin
            check("accept_timeout", LAT, bound, 0);
            req_valid = 2'b00;
            pend = 0;
          end else begin
            @(negedge clk);
          end
        end
      end
    endtask

    task automatic mid_reset();
      longint t;
      longint dummy;
      @(negedge clk);
      req_addr[0] = 8'h60;
      req_len[0]  = 9'd8;
      req_valid   = 2'b01;
      #2;
      check("grant_mid_reset", LAT, req_ready, 1);
      t = cyc;
      push_burst(0, 'h60, 8, t, dummy);
      @(negedge clk);
      req_valid = 2'b00;
      while (cyc < t + 3) @(negedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      check("outputs_zero_mid_reset", LAT,
            {req_ready, bram_en, bram_addr, rsp_valid, rsp_data, rsp_last, done, busy}, 0);
      addr_q.delete();
      rsp_q.delete();
      done_q.delete();
      last_grant = 1;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (12) @(negedge clk);
      #2;
      check("idle_after_reset", LAT, {busy, bram_en, rsp_valid, done}, 0);
    endtask

    initial begin
      logic [1:0] v;
      int n0, n1;
      rst_n      = 1'b0;
      req_valid  = 2'b11;
      req_addr   = '0;
      req_len    = '0;
      last_grant = 1;
      repeat (3) @(negedge clk);
      #2;
      check("outputs_zero_in_reset", LAT,
            {req_ready, bram_en, bram_addr, rsp_valid, rsp_data, rsp_last, done, busy}, 0);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      check("ready_after_reset", LAT, req_ready, 1);
      req_valid = 2'b00;

      run(2'b01, 'h10, 4, 0, 0);
      run(2'b11, 'h20, 2, 'h40, 2);
      run(2'b11, 'h30, 2, 'h50, 2);
      run(2'b10, 0, 0, 'hFE, 4);
      run(2'b01, 'h33, 0, 0, 0);
      run(2'b10, 0, 0, 'h80, 300);
      mid_reset();
      run(2'b11, 'h05, 3, 'h07, 1);

      for (int i = 0; i < 24; i++) begin
        v  = 2'($urandom_range(1, 3));
        n0 = ($urandom_range(0, 7) == 0) ? $urandom_range(250, 511) : $urandom_range(0, 12);
        n1 = ($urandom_range(0, 7) == 0) ? $urandom_range(250, 511) : $urandom_range(0, 12);
        run(v, $urandom_range(0, 255), n0, $urandom_range(0, 255), n1);
      end
      fin_l = 1'b1;
    end
  end

  initial begin
    int t;
    t = 0;
    while (!(lane[0].fin_l && lane[1].fin_l) && t < 60000) begin
      @(posedge clk);
      t++;
    end
    check("all_lanes_finished", 0, {lane[1].fin_l, lane[0].fin_l}, 3);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
